// File: rtl/adf4158_pkg.sv
// adf4158_pkg
//   Definitions shared by the ADF4158 configuration writer and receiver:
//   register control-field codes, shadow-bank indices, field bit positions,
//   the receiver state type and the control-field to bank-index decode.
package adf4158_pkg;

    // Control field w[2:0]
    localparam logic [2:0] R0 = 3'd0;
    localparam logic [2:0] R1 = 3'd1;
    localparam logic [2:0] R2 = 3'd2;
    localparam logic [2:0] R3 = 3'd3;
    localparam logic [2:0] R4 = 3'd4;
    localparam logic [2:0] R5 = 3'd5;
    localparam logic [2:0] R6 = 3'd6;
    localparam logic [2:0] R7 = 3'd7;

    // Shadow bank indices
    localparam logic [3:0] IDX_R0   = 4'd0;
    localparam logic [3:0] IDX_R1   = 4'd1;
    localparam logic [3:0] IDX_R2   = 4'd2;
    localparam logic [3:0] IDX_R3   = 4'd3;
    localparam logic [3:0] IDX_R4   = 4'd4;
    localparam logic [3:0] IDX_R5_0 = 4'd5;
    localparam logic [3:0] IDX_R5_1 = 4'd6;
    localparam logic [3:0] IDX_R6_0 = 4'd7;
    localparam logic [3:0] IDX_R6_1 = 4'd8;
    localparam logic [3:0] IDX_R7   = 4'd9;
    localparam int unsigned BANK_DEPTH = 10;

    // Field bit positions
    localparam int unsigned RAMP_EN_BIT = 31;
    localparam int unsigned INT_HI      = 26;
    localparam int unsigned INT_LO      = 15;
    localparam int unsigned FRAC_MSB_HI = 14;
    localparam int unsigned FRAC_MSB_LO = 3;
    localparam int unsigned FRAC_LSB_HI = 27;
    localparam int unsigned FRAC_LSB_LO = 15;
    localparam int unsigned SEL_BIT     = 23;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_SHIFT,
        RX_LATCH
    } rx_state_t;

    // R5 and R6 each have two banks selected by w[SEL_BIT]
    function automatic logic [3:0] bank_idx(input logic [31:0] w);
        case (w[2:0])
            R0:      return IDX_R0;
            R1:      return IDX_R1;
            R2:      return IDX_R2;
            R3:      return IDX_R3;
            R4:      return IDX_R4;
            R5:      return w[SEL_BIT] ? IDX_R5_1 : IDX_R5_0;
            R6:      return w[SEL_BIT] ? IDX_R6_1 : IDX_R6_0;
            default: return IDX_R7;
        endcase
    endfunction

endpackage

// File: rtl/adf4158_spi_rx_sync_edge_det.sv
// sync_edge_det
//   N-stage synchronizer for an asynchronous pin followed by a history flop
//   that yields single-cycle rise/fall pulses.
//   clk_i   fabric clock
//   rst_n_i synchronous active-low reset
//   d_i     asynchronous pin
//   sync_o  synchronized level
//   rise_o  one-cycle pulse on a synchronized 0->1 transition
//   fall_o  one-cycle pulse on a synchronized 1->0 transition
module sync_edge_det #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign sync_o = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~hist_q;
    assign fall_o = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/adf4158_spi_rx.sv
// adf4158_spi_rx
//   Device-side receiver for the ADF4158 3-wire interface. Oversamples
//   sclk/sdata/le, rebuilds 32-bit writes, decodes them into a 10-entry
//   shadow bank and exposes the live ramp-enable, INT and FRAC values.
//   clk, rst_n        fabric clock (>= 4x sclk), synchronous active-low reset
//   sclk, sdata, le   asynchronous serial pins
//   word_valid/data/idx  pulse + last good word and its bank index
//   frame_err         pulse when le rose with a bit count other than 32
//   bank_rd_idx/data  registered shadow bank read (indices 10-15 read 0)
//   bank_loaded       per-entry written flags; config_complete = all set
//   ramp_en, int_val, frac_val, freq_update  live R0-derived values
module adf4158_spi_rx
    import adf4158_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter logic        SAMPLE_RISING = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sclk,
    input  logic        sdata,
    input  logic        le,
    output logic        word_valid,
    output logic [31:0] word_data,
    output logic [3:0]  word_idx,
    output logic        frame_err,
    input  logic [3:0]  bank_rd_idx,
    output logic [31:0] bank_rd_data,
    output logic [9:0]  bank_loaded,
    output logic        config_complete,
    output logic        ramp_en,
    output logic [11:0] int_val,
    output logic [24:0] frac_val,
    output logic        freq_update
);

    localparam int unsigned STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic sclk_rise, sclk_fall, sdata_sync, le_rise, le_fall;
    logic sclk_sync, le_sync, sdata_rise, sdata_fall;

    sync_edge_det #(.STAGES(STAGES)) u_sync_sclk (
        .clk_i(clk), .rst_n_i(rst_n), .d_i(sclk),
        .sync_o(sclk_sync), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    sync_edge_det #(.STAGES(STAGES)) u_sync_sdata (
        .clk_i(clk), .rst_n_i(rst_n), .d_i(sdata),
        .sync_o(sdata_sync), .rise_o(sdata_rise), .fall_o(sdata_fall)
    );
    sync_edge_det #(.STAGES(STAGES)) u_sync_le (
        .clk_i(clk), .rst_n_i(rst_n), .d_i(le),
        .sync_o(le_sync), .rise_o(le_rise), .fall_o(le_fall)
    );

    logic unused_sync;
    assign unused_sync = &{1'b0, sclk_sync, le_sync, sdata_rise, sdata_fall};

    logic sclk_edge;
    assign sclk_edge = SAMPLE_RISING ? sclk_rise : sclk_fall;

    rx_state_t   state_q;
    logic [31:0] shreg_q;
    logic [5:0]  cnt_q;
    logic [31:0] bank_q [BANK_DEPTH];
    logic [9:0]  bank_loaded_q;
    logic [12:0] frac_lsb_q;
    logic        word_valid_q, frame_err_q, freq_update_q, ramp_en_q;
    logic [31:0] word_data_q, bank_rd_data_q;
    logic [3:0]  word_idx_q;
    logic [11:0] int_val_q;
    logic [24:0] frac_val_q;
    logic [3:0]  commit_idx;

    assign commit_idx = bank_idx(shreg_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= RX_IDLE;
            shreg_q        <= '0;
            cnt_q          <= '0;
            bank_loaded_q  <= '0;
            frac_lsb_q     <= '0;
            word_valid_q   <= 1'b0;
            frame_err_q    <= 1'b0;
            freq_update_q  <= 1'b0;
            ramp_en_q      <= 1'b0;
            word_data_q    <= '0;
            word_idx_q     <= '0;
            int_val_q      <= '0;
            frac_val_q     <= '0;
            bank_rd_data_q <= '0;
            for (int unsigned i = 0; i < BANK_DEPTH; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            word_valid_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            freq_update_q <= 1'b0;

            if (bank_rd_idx < 4'(BANK_DEPTH)) begin
                bank_rd_data_q <= bank_q[bank_rd_idx];
            end else begin
                bank_rd_data_q <= '0;
            end

            case (state_q)
                RX_IDLE: begin
                    if (le_fall) begin
                        state_q <= RX_SHIFT;
                        cnt_q   <= '0;
                    end
                end
                RX_SHIFT: begin
                    // A bit arriving with the le rise is still counted: the
                    // updated count is what LATCH inspects.
                    if (sclk_edge) begin
                        shreg_q <= {shreg_q[30:0], sdata_sync};
                        if (cnt_q != 6'd33) begin
                            cnt_q <= cnt_q + 6'd1;
                        end
                    end
                    if (le_rise) begin
                        state_q <= RX_LATCH;
                    end
                end
                RX_LATCH: begin
                    if (cnt_q == 6'd32) begin
                        word_valid_q              <= 1'b1;
                        word_data_q               <= shreg_q;
                        word_idx_q                <= commit_idx;
                        bank_q[commit_idx]        <= shreg_q;
                        bank_loaded_q[commit_idx] <= 1'b1;
                        // R1 only stages the FRAC LSBs; R0 applies them.
                        if (commit_idx == IDX_R1) begin
                            frac_lsb_q <= shreg_q[FRAC_LSB_HI:FRAC_LSB_LO];
                        end
                        if (commit_idx == IDX_R0) begin
                            ramp_en_q     <= shreg_q[RAMP_EN_BIT];
                            int_val_q     <= shreg_q[INT_HI:INT_LO];
                            frac_val_q    <= {shreg_q[FRAC_MSB_HI:FRAC_MSB_LO], frac_lsb_q};
                            freq_update_q <= 1'b1;
                        end
                    end else begin
                        frame_err_q <= 1'b1;
                    end
                    state_q <= RX_IDLE;
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign word_valid      = word_valid_q;
    assign word_data       = word_data_q;
    assign word_idx        = word_idx_q;
    assign frame_err       = frame_err_q;
    assign bank_rd_data    = bank_rd_data_q;
    assign bank_loaded     = bank_loaded_q;
    assign config_complete = &bank_loaded_q;
    assign ramp_en         = ramp_en_q;
    assign int_val         = int_val_q;
    assign frac_val        = frac_val_q;
    assign freq_update     = freq_update_q;

endmodule

// File: doc/adf4158_spi_rx.md
Name: adf4158_spi_rx

Overview:
- Receiver for the ADF4158 3-wire configuration interface (SCLK, DATA, LE). It is the device-side counterpart of the adf4158 configuration writer.
- Oversamples the pins with the fabric clock, rebuilds each 32-bit register write and decodes the control bits into a 10-entry shadow bank.
- Exposes the live ramp-enable, INT and FRAC values.
- Used in loopback self-test and as a synthesizable bus monitor/checker in benches.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on each of sclk/sdata/le before edge detection (minimum 2).
- SAMPLE_RISING, 1'b1, 1 = shift sdata on sclk rising edge (device behaviour); 0 = falling edge.

Ports:
- clk  in  1  fabric clock; must be >= 4x sclk frequency.
- rst_n  in  1  reset.
- sclk  in  1  serial clock pin, asynchronous to clk.
- sdata  in  1  serial data pin, MSB first.
- le  in  1  load enable pin; low while shifting, rising edge latches the word.
- word_valid  out  1  one-cycle pulse: a good 32-bit word was latched.
- word_data  out  32  last good word; held until the next good word.
- word_idx  out  4  bank index of word_data.
- frame_err  out  1  one-cycle pulse: LE rose with bit count != 32.
- bank_rd_idx  in  4  shadow bank read address.
- bank_rd_data  out  32  shadow bank read data, 1-cycle latency.
- bank_loaded  out  10  bit i set once bank entry i has been written.
- config_complete  out  1  high when bank_loaded == all ones.
- ramp_en  out  1  R0 bit 31 from the last R0 write.
- int_val  out  12  R0[26:15].
- frac_val  out  25  {R0[14:3], pending R1[27:15]}.
- freq_update  out  1  one-cycle pulse on each good R0 write.

Reset: rst_n, synchronous, active-low; clock clk.

Behaviour:
- Reset values:
  - All outputs 0; bank entries 0; bank_loaded 0; pending FRAC LSB 0.
  - Shift register 0; bit count 0; synchronizer stages 0.
- Synchronizing: each pin passes through SYNC_STAGES flops, plus one history flop for edge detection. Pin-to-detect latency is SYNC_STAGES+1 clk.
- Receiver FSM states:
  - IDLE:
    - Enter SHIFT on detected le falling edge, clearing bit count.
    - Sclk edges are ignored.
    - An le rising edge while in IDLE does nothing.
  - SHIFT:
    - On the selected sclk edge: shreg <= {shreg[30:0], sdata_sync}.
    - Bit count increments and saturates at 33.
    - On le rising edge go to LATCH.
  - LATCH (1 cycle):
    - If count == 32, commit the word, then go to IDLE.
    - Otherwise pulse frame_err, leave the bank untouched, then go to IDLE.
- Simultaneous events: if an sclk edge and an le rising edge are detected in the same cycle, the shift is applied first and the count includes that bit.
- Decode of committed word w (control field c = w[2:0]):
  - c = 0..4: idx = c.
  - c = 5: idx = 5 + w[23] (DEV_SEL).
  - c = 6: idx = 7 + w[23] (STEP_SEL).
  - c = 7: idx = 9.
- Commit timing:
  - Commit happens in the LATCH cycle; outputs are visible the following cycle.
  - word_valid pulses 1 cycle, with word_data/word_idx updated.
  - bank[idx] <= w and bank_loaded[idx] <= 1.
- Double buffering:
  - An R1 write (idx 1) updates only the pending FRAC LSB (w[27:15]); frac_val does not change.
  - An R0 write updates ramp_en, int_val and frac_val together (frac_val = {w[14:3], pending}), and pulses freq_update.
- Reset mid-frame: the partial word is discarded and the FSM returns to IDLE. The next complete frame decodes normally.
- Repeated writes overwrite bank entries; there is no history.
- Bank read: a registered read of bank[bank_rd_idx]. Indices 10-15 return 0.

Decomposition:
- Shared package adf4158_pkg holds:
  - Control-field constants R0..R7.
  - Bank index constants IDX_R0..IDX_R7 (R5_0 = 5, R5_1 = 6, R6_0 = 7, R6_1 = 8, R7 = 9) and bank depth 10.
  - Field bit positions: RAMP_EN 31, INT 26:15, FRAC_MSB 14:3, FRAC_LSB 27:15, SEL 23.
- The writer and the receiver share this package.
- One sub-module, sync_edge_det (N-stage synchronizer plus rise/fall pulse), instantiated three times.

Test Plan:
- Single R7 frame 0x0000_0007 at sclk = clk/8 -> word_valid one cycle, word_idx = 9, bank[9] = 0x0000_0007, frame_err 0.
- R5 frame with bit 23 = 1, then with bit 23 = 0 -> word_idx 6 then 5, both bank_loaded bits set.
- 31 bits then le rise, and separately 34 bits then le rise -> frame_err pulse each time, no word_valid, bank_loaded unchanged.
- Full default sequence R7, R6_1, R6_0, R5_1, R5_0, R4..R0 (INT = 265, FRAC = 0, ramp_en = 0) -> config_complete = 1, int_val = 265, frac_val = 0, ramp_en = 0. A following R0 write with bit 31 = 1 -> ramp_en = 1 and freq_update pulse.
- R1 with FRAC LSB = 0x1ABC -> frac_val unchanged and no freq_update. A following R0 with FRAC MSB = 0x003 -> frac_val = {12'h003, 13'h1ABC}.
- rst_n low for 1 cycle after 16 bits of a frame -> all outputs 0. The next full R2 frame gives word_idx = 2 and the correct bank[2].
